// File: rtl/cpu_bank_reg_file.sv
// Architectural register bank with a pending-write scoreboard and hardwired-zero r0.
// Optional same-cycle write-to-read forwarding: define CPU_BANK_REG_BYPASS_EN.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module cpu_bank_reg_cell #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_i,
  input  logic [REG_WIDTH-1:0] wdata_i,
  input  logic                 set_i,
  output logic [REG_WIDTH-1:0] data_o,
  output logic                 busy_o
);
  logic [REG_WIDTH-1:0] data_q;
  logic                 busy_q, busy_d;

  // A producer issued in the same cycle the previous one retires keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    if (set_i)     busy_d = 1'b1;
    else if (wr_i) busy_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      if (wr_i) data_q <= wdata_i;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
endmodule

module cpu_bank_reg_file #(
  parameter  int NUM_REGS  = `NUM_REGS,
  parameter  int REG_WIDTH = `REG_WIDTH,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        read_reg_a,
  input  logic [AW-1:0]        read_reg_b,
  input  logic [AW-1:0]        write_reg,
  input  logic [REG_WIDTH-1:0] write_data,
  input  logic                 write_enable,
  input  logic                 busy_set,
  input  logic [AW-1:0]        busy_reg,
  output logic [REG_WIDTH-1:0] read_data_a,
  output logic [REG_WIDTH-1:0] read_data_b,
  output logic                 hazard_a,
  output logic                 hazard_b,
  output logic [NUM_REGS-1:0]  busy_vec
);
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                busy;

  // r0 has no storage: constant zero, never pending.
  assign regs[0] = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic wr_sel, set_sel;
    assign wr_sel  = write_enable && (write_reg == AW'(r));
    assign set_sel = busy_set && (busy_reg == AW'(r));
    cpu_bank_reg_cell #(.REG_WIDTH(REG_WIDTH)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (wr_sel),
      .wdata_i (write_data),
      .set_i   (set_sel),
      .data_o  (regs[r]),
      .busy_o  (busy[r])
    );
  end

  logic fwd_a, fwd_b;
`ifdef CPU_BANK_REG_BYPASS_EN
  assign fwd_a = write_enable && (write_reg == read_reg_a) && (read_reg_a != '0);
  assign fwd_b = write_enable && (write_reg == read_reg_b) && (read_reg_b != '0);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign read_data_a = fwd_a ? write_data : regs[read_reg_a];
  assign read_data_b = fwd_b ? write_data : regs[read_reg_b];
  assign hazard_a    = busy[read_reg_a] & ~fwd_a;
  assign hazard_b    = busy[read_reg_b] & ~fwd_b;
  assign busy_vec    = busy;
endmodule

// File: tb/tb_cpu_bank_reg_file.sv
// Directed and model-checked random stimulus for cpu_bank_reg_file (both bypass builds).
module tb_cpu_bank_reg_file;
  localparam int NUM_REGS  = 32;
  localparam int REG_WIDTH = 32;
  localparam int AW        = 5;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [AW-1:0]        read_reg_a = '0, read_reg_b = '0, write_reg = '0, busy_reg = '0;
  logic [REG_WIDTH-1:0] write_data = '0;
  logic                 write_enable = 1'b0, busy_set = 1'b0;
  logic [REG_WIDTH-1:0] read_data_a, read_data_b;
  logic                 hazard_a, hazard_b;
  logic [NUM_REGS-1:0]  busy_vec;

  cpu_bank_reg_file #(.NUM_REGS(NUM_REGS), .REG_WIDTH(REG_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_reg_a(read_reg_a), .read_reg_b(read_reg_b),
    .write_reg(write_reg), .write_data(write_data), .write_enable(write_enable),
    .busy_set(busy_set), .busy_reg(busy_reg),
    .read_data_a(read_data_a), .read_data_b(read_data_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

`ifdef CPU_BANK_REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic [REG_WIDTH-1:0] m_regs [NUM_REGS];
  logic [NUM_REGS-1:0]  m_busy;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy = '0;
  endtask

  task automatic drive(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic we,
                       input logic [AW-1:0] wr, input logic [31:0] wd,
                       input logic bs, input logic [AW-1:0] br);
    read_reg_a = ra; read_reg_b = rb; write_enable = we; write_reg = wr;
    write_data = wd; busy_set = bs; busy_reg = br;
  endtask

  // Advance one edge and apply the reference update for the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_clear();
    else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (busy_set && busy_reg == AW'(r)) m_busy[r] = 1'b1;
        else if (write_enable && write_reg == AW'(r)) m_busy[r] = 1'b0;
      end
      if (write_enable && write_reg != '0) m_regs[write_reg] = write_data;
    end
    #1;
  endtask

  function automatic logic m_fwd(input logic [AW-1:0] ra);
    return BYP && write_enable && write_reg == ra && ra != '0;
  endfunction

  task automatic chk_model();
    chk("rand_rda", read_data_a, m_fwd(read_reg_a) ? write_data : m_regs[read_reg_a]);
    chk("rand_rdb", read_data_b, m_fwd(read_reg_b) ? write_data : m_regs[read_reg_b]);
    chk("rand_hza", 32'(hazard_a), 32'(m_busy[read_reg_a] & ~m_fwd(read_reg_a)));
    chk("rand_hzb", 32'(hazard_b), 32'(m_busy[read_reg_b] & ~m_fwd(read_reg_b)));
    chk("rand_busy", busy_vec, m_busy);
  endtask

  initial begin
    m_clear();
    #2;
    chk("rst_rda", read_data_a, 0);
    chk("rst_hza", 32'(hazard_a), 0);
    chk("rst_busy", busy_vec, 0);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < NUM_REGS; i++) begin
      drive(AW'(i), AW'(NUM_REGS - 1 - i), 1'b0, '0, '0, 1'b0, '0);
      #1;
      chk("init_rda", read_data_a, 0);
      chk("init_rdb", read_data_b, 0);
    end

    drive(0, 0, 1'b1, 3, 'h12345678, 1'b0, 0); tick();
    drive(3, 3, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r3_rda", read_data_a, 'h12345678);
    chk("r3_rdb", read_data_b, 'h12345678);
    chk("r3_hza", 32'(hazard_a), 0);
    chk("r3_hzb", 32'(hazard_b), 0);

    drive(0, 0, 1'b1, 0, 'hFFFFFFFF, 1'b1, 0); tick();
    drive(0, 0, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r0_rda", read_data_a, 0);
    chk("r0_busy0", 32'(busy_vec[0]), 0);
    chk("r0_hza", 32'(hazard_a), 0);

    drive(0, 0, 1'b0, 0, 0, 1'b1, 7); tick();
    drive(7, 0, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r7_pend_hza", 32'(hazard_a), 1);
    drive(7, 0, 1'b1, 7, 'hA5A5A5A5, 1'b0, 0); #1;
    chk("r7_wcyc_rda", read_data_a, BYP ? 'hA5A5A5A5 : 0);
    chk("r7_wcyc_hza", 32'(hazard_a), BYP ? 0 : 1);
    tick();
    drive(7, 0, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r7_after_rda", read_data_a, 'hA5A5A5A5);
    chk("r7_after_hza", 32'(hazard_a), 0);
    chk("r7_after_busy", busy_vec, 0);

    drive(0, 0, 1'b1, 9, 'h1, 1'b1, 9); tick();
    drive(9, 0, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r9_busy", busy_vec, 32'h0000_0200);
    chk("r9_rda", read_data_a, 'h1);
    chk("r9_hza", 32'(hazard_a), 1);

    drive(0, 0, 1'b1, 5, 'hDEADBEEF, 1'b1, 11); tick();
    drive(5, 11, 1'b0, 0, 0, 1'b0, 0); #1;
    chk("r5_rda", read_data_a, 'hDEADBEEF);
    chk("r11_hzb", 32'(hazard_b), 1);
    rst_n = 1'b0; #1;
    chk("midrst_rda", read_data_a, 0);
    chk("midrst_busy", busy_vec, 0);
    chk("midrst_hzb", 32'(hazard_b), 0);
    tick();
    chk("midrst_hold_busy", busy_vec, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("postrst_rda", read_data_a, 0);
    chk("postrst_busy", busy_vec, 0);

    // Narrow address range forces a/b aliasing, write/read collisions and back-to-back writes.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] ra, rb, wr, br;
      ra = AW'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, 7));
      wr = ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, 7));
      br = AW'($urandom_range(0, 7));
      drive(ra, rb, $urandom_range(0, 1) == 1, wr, $urandom, $urandom_range(0, 4) < 2, br);
      #1;
      chk_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/cpu_bank_reg_file.md
Name: cpu_bank_reg_file

Overview:
Register-bank responder for the CPU bank-register interface. It receives read addresses a/b, write address, write data and write enable, and returns read data a/b. The bank also holds a per-register pending-write scoreboard, so decode can stall on operands whose producer has not yet written back. It sits between decode (reads, busy marking) and writeback (writes).

Parameters:
NUM_REGS, `NUM_REGS (32), number of architectural registers; power of two, >= 2
REG_WIDTH, `REG_WIDTH (32), data width of each register
AW, $clog2(NUM_REGS), address width (derived; not overridden)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
read_reg_a  input  AW  read port A address
read_reg_b  input  AW  read port B address
write_reg  input  AW  write port address
write_data  input  REG_WIDTH  write port data
write_enable  input  1  commit write_data to write_reg on this edge
busy_set  input  1  mark busy_reg as pending (destination issued)
busy_reg  input  AW  register to mark pending
read_data_a  output  REG_WIDTH  port A data
read_data_b  output  REG_WIDTH  port B data
hazard_a  output  1  port A operand not yet available
hazard_b  output  1  port B operand not yet available
busy_vec  output  NUM_REGS  current scoreboard, bit i = register i pending

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low. While rst_n=0, all registers = 0 and busy_vec = 0. Outputs follow combinationally from the cleared state: read_data_* = 0, hazard_* = 0.
- Register 0 is hardwired zero:
  - Writes to 0 are discarded.
  - busy_set with busy_reg=0 is ignored.
  - Reads of 0 return 0 with hazard = 0.
- Write: on a rising edge with write_enable=1 and write_reg != 0, regs[write_reg] <= write_data. Visible in the array from the next cycle.
- Read: combinational, zero-cycle latency. read_data_x = regs[read_reg_x], modified by the optional bypass.
- Scoreboard update per edge, for register r:
  - If busy_set=1 and busy_reg=r (r != 0), busy[r] <= 1.
  - Else if write_enable=1 and write_reg=r, busy[r] <= 0.
  - Else busy[r] holds.
  - Simultaneous set and clear on the same register: set wins. A new producer was issued in the same cycle the old one retired.
- Hazard: hazard_x = busy[read_reg_x] & ~fwd_x.
  - fwd_x = bypass match (write_enable & write_reg == read_reg_x & read_reg_x != 0) when the bypass is compiled in; 0 otherwise.
- Both read ports may address the same register; each is evaluated independently.
- Write to a register that is not busy: allowed. Data updates; busy stays 0.
- Reset asserted mid-operation clears the array and scoreboard immediately. No pending write survives reset.
- No X propagation: out-of-range addresses cannot occur, since NUM_REGS is a power of two.

Optional Feature:
Macro CPU_BANK_REG_BYPASS_EN.
- Defined: write-to-read forwarding. When write_enable=1, write_reg=read_reg_x and read_reg_x != 0, read_data_x = write_data in the same cycle and hazard_x = 0.
- Undefined: reads always return the array contents. A same-cycle write is seen next cycle, and hazard_x stays asserted until the edge that clears busy.

Test Plan:
- Reset then read all registers. Pulse rst_n=0 mid-run after writing r5=0xDEADBEEF → read_data_a(r5)=0, busy_vec=0 during and after reset.
- Write r3=0x12345678, next cycle read_reg_a=3, read_reg_b=3 → both read_data=0x12345678, hazards 0.
- Write r0=0xFFFFFFFF with busy_set, busy_reg=0 → read r0 = 0, busy_vec[0]=0, hazard_a=0.
- busy_set r7; read r7 next cycle → hazard_a=1. Then write r7=0xA5A5A5A5:
  - With CPU_BANK_REG_BYPASS_EN: read_data_a=0xA5A5A5A5, hazard_a=0 in the write cycle.
  - Without it: hazard_a=1 in the write cycle, then 0 and data 0xA5A5A5A5 the following cycle.
- Same edge: busy_set r9 and write_enable r9=0x1 → busy_vec[9]=1 after the edge, regs[9]=0x1.
- Random stream of writes, busy_set and reads on both ports, checked against a reference model. Covered: same-address a/b, write/read collisions, back-to-back writes to one register.
